// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its helpers.
//   arb_state_e : arbiter FSM state encoding (IDLE, WRITE, GAP)
//   FULL_LAG    : cycles by which the FIFO full flag trails a write
//   clog2       : index width helper that never returns less than 1
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned FULL_LAG = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO-write bundle for fifo_wr_arbiter.
//   req, req_data : per-requester request and packed data (slice i at i*WIDTH)
//   ack           : one-hot word-taken pulse
//   fifo_full     : FIFO full flag (lags writes by FULL_LAG cycles)
//   fifo_wr_en, fifo_wr_data : FIFO write port
//   grant_id      : index of the last granted requester
//   busy          : arbiter is in WRITE or GAP
// master = arbiter side, slave = requesters + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  modport master (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   elig  : eligibility vector
//   ptr   : last granted index; search starts at ptr+1 and wraps
//   idx   : first eligible index found
//   valid : some requester is eligible
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Two ascending passes: indices above ptr first, then the wrapped part.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!valid && elig[j] && (IW'(j) > ptr)) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!valid && elig[j] && (IW'(j) <= ptr)) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter for the dual-clock FIFO write port.
// Shares one FIFO write port between NREQ requesters and inserts WR_GAP
// idle cycles after each write so the lagging full flag is never outrun.
//   wr_clk : write-domain clock
//   rst_n  : synchronous active-low reset
//   bus    : requester handshake + FIFO write port (master modport)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 1,
  parameter int unsigned WR_GAP    = FULL_LAG
) (
  input  logic                wr_clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.master   bus
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned GW = clog2(WR_GAP + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [3:0]       burst_q, burst_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             wr_en_q;
  logic [WIDTH-1:0] data_q, sel_data;
  logic [IW-1:0]    gid_q;
  logic             busy_q;

  logic [NREQ-1:0]  elig;
  logic [IW-1:0]    rr_idx, sel;
  logic             rr_valid;
  logic             owner_in_burst, owner_keep, owner_hold, can_issue, issue;

  // A requester whose ack is high this cycle still shows its old word.
  assign elig = bus.req & ~ack_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // burst_q == 0 means no owner yet (after reset), so the pointer alone decides.
  assign owner_in_burst = (burst_q != 4'd0) && (burst_q < 4'(MAX_BURST)) && bus.req[ptr_q];
  assign owner_keep     = owner_in_burst && !ack_q[ptr_q];
  // Owner mid-burst but still in its ack cycle: wait for it instead of rotating.
  assign owner_hold     = owner_in_burst && ack_q[ptr_q];
  assign can_issue      = !bus.fifo_full && !owner_hold && (owner_keep || rr_valid);
  assign sel            = owner_keep ? ptr_q : rr_idx;

  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (sel == IW'(j)) sel_data = bus.req_data[j*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    burst_d = 4'd1;
    if (owner_keep) burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
  end

  // Gap expiry uses the same issue rule as IDLE so writes can be WR_GAP+1 apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          issue   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (WR_GAP > 0) begin
          state_d = GAP;
          gap_d   = GW'(1);
        end else if (can_issue) begin
          issue   = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q >= GW'(WR_GAP)) begin
          gap_d = '0;
          if (can_issue) begin
            issue   = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = (gap_q == '1) ? gap_q : gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (issue) ack_d[sel] = 1'b1;
  end

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      burst_q <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      wr_en_q <= issue;
      busy_q  <= (state_d != IDLE);
      if (issue) begin
        data_q  <= sel_data;
        gid_q   <= sel;
        ptr_q   <= sel;
        burst_q <= burst_d;
      end
    end
  end

  assign bus.ack          = ack_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = data_q;
  assign bus.grant_id     = gid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, rotation, full stall,
// burst with WR_GAP=0, reset in GAP, and pairing with a depth-8 FIFO model.
module tb_fifo_wr_arbiter;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_errs   = 0;

  fifo_wr_arbiter_if #(.WIDTH(64), .NREQ(4)) bus_a ();
  fifo_wr_arbiter_if #(.WIDTH(64), .NREQ(4)) bus_b ();

  fifo_wr_arbiter #(.WIDTH(64), .NREQ(4), .MAX_BURST(1), .WR_GAP(2)) dut_a (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus_a.master)
  );

  fifo_wr_arbiter #(.WIDTH(64), .NREQ(4), .MAX_BURST(4), .WR_GAP(0)) dut_b (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus_b.master)
  );

  // Depth-8 FIFO model: full register follows the stored count one edge later,
  // i.e. full appears two cycles after the write strobe that filled it.
  logic        force_full = 1'b0;
  logic        m_en       = 1'b0;
  logic        m_rd       = 1'b0;
  logic        m_full     = 1'b0;
  int          m_lost     = 0;
  logic [63:0] mq[$];
  logic [63:0] popped[$];

  assign bus_a.fifo_full = force_full | (m_en & m_full);
  assign bus_b.fifo_full = 1'b0;

  always @(posedge wr_clk) begin
    if (!m_en) begin
      mq.delete();
      m_full <= 1'b0;
    end else begin
      m_full <= (mq.size() >= 8);
      if (bus_a.fifo_wr_en) begin
        if (mq.size() >= 8) m_lost++;
        else mq.push_back(bus_a.fifo_wr_data);
      end
      if (m_rd && mq.size() > 0) popped.push_back(mq.pop_front());
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  bit   we_tab [10] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1};
  int   id_tab [10] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
  int   acked;

  initial begin
    bus_a.req      = 4'b1111;
    bus_a.req_data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    bus_b.req      = 4'b0000;
    bus_b.req_data = {64'hB3, 64'hB2, 64'hB1, 64'hB0};

    // 1: reset held 3 cycles with all requests up
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ctl", {59'd0, bus_a.busy, bus_a.fifo_wr_en, bus_a.ack}, 64'd0);
      check("rst_gid_data", bus_a.fifo_wr_data | 64'(bus_a.grant_id), 64'd0);
    end
    rst_n = 1'b1;

    // 2: rotation A0..A3,A0 every 3 cycles
    for (int k = 0; k <= 12; k++) begin
      step();
      check("rr_wr_en", 64'(bus_a.fifo_wr_en), 64'((k % 3) == 0));
      check("rr_gid", 64'(bus_a.grant_id), 64'((k / 3) % 4));
      check("rr_busy", 64'(bus_a.busy), 64'd1);
      if ((k % 3) == 0) begin
        check("rr_data", bus_a.fifo_wr_data, 64'hA0 + 64'((k / 3) % 4));
        check("rr_ack", 64'(bus_a.ack), 64'(1) << ((k / 3) % 4));
      end else begin
        check("rr_ack_idle", 64'(bus_a.ack), 64'd0);
      end
    end
    bus_a.req = 4'b0000;
    settle(4);

    // 3: full stall then release
    force_full = 1'b1;
    bus_a.req  = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      check("full_wr_en", {62'd0, bus_a.fifo_wr_en, |bus_a.ack}, 64'd0);
    end
    force_full = 1'b0;
    step();
    check("full_rel_wr_en", 64'(bus_a.fifo_wr_en), 64'd1);
    check("full_rel_data", bus_a.fifo_wr_data, 64'hA2);
    check("full_rel_gid", 64'(bus_a.grant_id), 64'd2);
    check("full_rel_ack", 64'(bus_a.ack), 64'b0100);
    bus_a.req = 4'b0000;
    settle(4);

    // 5: reset during GAP; owner 0 would otherwise lose to requester 3
    bus_a.req = 4'b0001;
    step();
    check("gaprst_wr0", {bus_a.fifo_wr_data[61:0], bus_a.fifo_wr_en, 1'b0}, {62'hA0, 2'b10});
    bus_a.req = 4'b0000;
    step();
    check("gaprst_busy_gap", 64'(bus_a.busy), 64'd1);
    rst_n = 1'b0;
    step();
    check("gaprst_busy", 64'(bus_a.busy), 64'd0);
    check("gaprst_gid", 64'(bus_a.grant_id), 64'd0);
    check("gaprst_wr_en", {62'd0, bus_a.fifo_wr_en, |bus_a.ack}, 64'd0);
    rst_n     = 1'b1;
    bus_a.req = 4'b1001;
    step();
    check("gaprst_after_gid", 64'(bus_a.grant_id), 64'd0);
    check("gaprst_after_data", bus_a.fifo_wr_data, 64'hA0);
    check("gaprst_after_ack", 64'(bus_a.ack), 64'b0001);
    bus_a.req = 4'b0000;
    settle(4);

    // 4: WR_GAP=0, MAX_BURST=4, requesters 1 and 2
    bus_b.req = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      step();
      check("burst_wr_en", 64'(bus_b.fifo_wr_en), 64'(we_tab[k]));
      check("burst_gid", 64'(bus_b.grant_id), 64'(id_tab[k]));
      check("burst_ack", 64'(bus_b.ack), we_tab[k] ? (64'(1) << id_tab[k]) : 64'd0);
      if (we_tab[k]) check("burst_data", bus_b.fifo_wr_data, 64'hB0 + 64'(id_tab[k]));
    end
    bus_b.req = 4'b0000;
    settle(2);

    // 6: requester 3 pushes 10 words into a stalled depth-8 FIFO
    m_en  = 1'b1;
    acked = 0;
    bus_a.req_data[3*64 +: 64] = 64'h100;
    bus_a.req = 4'b1000;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus_a.ack[3]) begin
        acked++;
        if (acked < 10) bus_a.req_data[3*64 +: 64] = 64'h100 + 64'(acked);
        else bus_a.req = 4'b0000;
      end
    end
    check("fifo_acks_stalled", 64'(acked), 64'd8);
    check("fifo_level", 64'(mq.size()), 64'd8);
    check("fifo_full_seen", 64'(bus_a.fifo_full), 64'd1);
    check("fifo_lost_stalled", 64'(m_lost), 64'd0);
    m_rd = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (acked == 10 && popped.size() == 10) break;
      step();
      if (bus_a.ack[3]) begin
        acked++;
        if (acked < 10) bus_a.req_data[3*64 +: 64] = 64'h100 + 64'(acked);
        else bus_a.req = 4'b0000;
      end
    end
    m_rd = 1'b0;
    check("fifo_acks_total", 64'(acked), 64'd10);
    check("fifo_popped", 64'(popped.size()), 64'd10);
    check("fifo_lost_total", 64'(m_lost), 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i < popped.size()) check("fifo_order", popped[i], 64'h100 + 64'(i));
    end
    m_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
